axi_master_bridge: RTL and testbench
====================================

// Module: axi_master_bridge
// PURPOSE
//  Sole AXI3 master of the core; drives the AXI ports exposed at the CPU top level. Merges instruction-fetch
//  reads, data reads and data writes from the cache/uncached units into one AR/R channel pair and one AW/W/B set.
//  One read burst and one write burst in flight at most; read and write paths run concurrently.
// PARAMETERS
//  LINE_W    4  log2 bytes per cache line; address bits [31:LINE_W] are compared for the read-after-write check
//  MAX_LEN   8  width of burst-length fields (AXI arlen/awlen encoding: beats-1)
// PORTS
//  aclk        in   1   clock; all logic on rising edge
//  areset      in   1   synchronous active-high reset
//  i_rd_req    in   1   ifetch read request; held until i_rd_gnt
//  i_rd_addr   in   32  ifetch burst start address
//  i_rd_len    in   8   ifetch beats-1
//  i_rd_gnt    out  1   1-cycle pulse: ifetch request accepted by AR channel
//  d_rd_req/d_rd_addr/d_rd_len  in 1/32/8  data read request, same rules as ifetch
//  d_rd_size   in   3   AXI size for data read (3'b010 for cached, byte/half for uncached)
//  d_rd_gnt    out  1   1-cycle pulse: data read accepted
//  i_rd_valid/d_rd_valid  out 1  beat of returned data for that requester
//  rd_data     out  32  returned beat (shared by both requesters)
//  rd_last     out  1   final beat of current read burst
//  d_wr_req/d_wr_addr/d_wr_len/d_wr_size  in 1/32/8/3  write burst request, held until d_wr_gnt
//  d_wr_gnt    out  1   1-cycle pulse: AW accepted
//  d_wd_valid/d_wd_data/d_wd_strb  in 1/32/4  write beat from requester
//  d_wd_ready  out  1   beat consumed this cycle
//  d_wr_done   out  1   1-cycle pulse on B response handshake
//  arid..arvalid, rready, awid..awvalid, wid, wdata, wstrb, wlast, wvalid, bready  out  AXI3 master outputs
//  arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid  in  AXI3 master inputs
// BEHAVIOUR
//  Reset: arvalid/rready/awvalid/wvalid/bready/all gnt,valid,done pulses = 0; araddr/awaddr/arlen/awlen = 0;
//   both FSMs to IDLE; beat counter 0. Reset mid-burst abandons the transaction (interconnect reset together).
//  Constants: arburst=awburst=2'b01 INCR, arlock=awlock=0, arcache=awcache=0, arprot=awprot=0, wid=awid=4'd1.
//  Read FSM R_IDLE->R_AR->R_DATA->R_IDLE:
//   R_IDLE: d_rd_req has priority over i_rd_req; data read blocked while write FSM != W_IDLE and
//    d_rd_addr[31:LINE_W]==latched write addr[31:LINE_W]. On pick: register araddr/arlen/arsize (ifetch size
//    3'b010), arid=0 ifetch / 1 data, owner bit; arvalid=1 next cycle; gnt pulse same cycle as pick.
//   R_AR: hold all AR signals stable until arvalid&arready, then R_DATA; arvalid drops the following cycle.
//   R_DATA: rready=1; each rvalid forwards rdata combinationally to rd_data, asserts owner's *_rd_valid;
//    rd_last=rlast; rvalid&rlast -> R_IDLE. rresp, rid ignored. New pick allowed the cycle after R_IDLE entry.
//  Write FSM W_IDLE->W_AW->W_DATA->W_B->W_IDLE:
//   W_IDLE: d_wr_req -> latch awaddr/awlen/awsize, d_wr_gnt pulse, W_AW. W_AW: awvalid until awready.
//   W_DATA: wvalid=d_wd_valid, wdata/wstrb pass through, d_wd_ready=wready; count beats on wvalid&wready;
//    wlast=(count==awlen); handshake with wlast -> W_B, counter to 0. AW and W strictly serialised.
//   W_B: bready=1; bvalid -> d_wr_done pulse, W_IDLE. bresp ignored.
//  Simultaneous: read and write FSMs independent; a data read and write issued same cycle both proceed
//   (address check uses only the previously latched write address). awlen=0 gives single beat, wlast on beat 0.
// TESTING
//  d_rd_req,addr 0x1C000100,len 3 & i_rd_req same cycle -> d_rd_gnt first, arid=1, 4 d_rd_valid, rd_last on 4th, then i gnt
//  arready low 5 cycles -> arvalid/araddr/arlen stable 5 cycles, no gnt repeat, R_DATA only after handshake
//  d_wr_req addr 0x200, len 3, wready toggling -> exactly 4 W beats, wlast on 4th, d_wr_done 1 cycle after bvalid
//  write to 0x1C000100 in W_B, d_rd_req same line -> no AR until d_wr_done; different line -> AR issued
//  single-beat uncached write awlen 0, size 3'b000, strb 4'b0100 -> wlast on first beat, awsize 0
//  areset asserted mid read burst -> next cycle arvalid=rready=0, FSMs IDLE, new request granted normally

Source files
------------

// File: rtl/axi_master_bridge_if.sv
// AXI3 master-side bus bundle for the CPU bridge. The master modport faces the core
// and the slave modport faces the interconnect.
interface axi_master_bridge_if #(
  parameter int MAX_LEN = 8
);
  logic [3:0]         arid;
  logic [31:0]        araddr;
  logic [MAX_LEN-1:0] arlen;
  logic [2:0]         arsize;
  logic [1:0]         arburst;
  logic [1:0]         arlock;
  logic [3:0]         arcache;
  logic [2:0]         arprot;
  logic               arvalid;
  logic               arready;
  logic [3:0]         rid;
  logic [31:0]        rdata;
  logic [1:0]         rresp;
  logic               rlast;
  logic               rvalid;
  logic               rready;
  logic [3:0]         awid;
  logic [31:0]        awaddr;
  logic [MAX_LEN-1:0] awlen;
  logic [2:0]         awsize;
  logic [1:0]         awburst;
  logic [1:0]         awlock;
  logic [3:0]         awcache;
  logic [2:0]         awprot;
  logic               awvalid;
  logic               awready;
  logic [3:0]         wid;
  logic [31:0]        wdata;
  logic [3:0]         wstrb;
  logic               wlast;
  logic               wvalid;
  logic               wready;
  logic [3:0]         bid;
  logic [1:0]         bresp;
  logic               bvalid;
  logic               bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_master_bridge.sv
// Sole AXI3 master of the core: arbitrates ifetch/data reads onto AR/R and data writes onto
// AW/W/B, one burst per direction in flight, with a same-line read-after-write hold-off.
module axi_master_bridge #(
  parameter int LINE_W  = 4,
  parameter int MAX_LEN = 8
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               i_rd_req,
  input  logic [31:0]        i_rd_addr,
  input  logic [MAX_LEN-1:0] i_rd_len,
  output logic               i_rd_gnt,
  input  logic               d_rd_req,
  input  logic [31:0]        d_rd_addr,
  input  logic [MAX_LEN-1:0] d_rd_len,
  input  logic [2:0]         d_rd_size,
  output logic               d_rd_gnt,
  output logic               i_rd_valid,
  output logic               d_rd_valid,
  output logic [31:0]        rd_data,
  output logic               rd_last,
  input  logic               d_wr_req,
  input  logic [31:0]        d_wr_addr,
  input  logic [MAX_LEN-1:0] d_wr_len,
  input  logic [2:0]         d_wr_size,
  output logic               d_wr_gnt,
  input  logic               d_wd_valid,
  input  logic [31:0]        d_wd_data,
  input  logic [3:0]         d_wd_strb,
  output logic               d_wd_ready,
  output logic               d_wr_done,
  axi_master_bridge_if.master axi
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B} wr_state_t;

  rd_state_t          r_rd_state, w_rd_next;
  wr_state_t          r_wr_state, w_wr_next;
  logic [31:0]        r_araddr, r_awaddr;
  logic [MAX_LEN-1:0] r_arlen, r_awlen, r_beat_cnt;
  logic [2:0]         r_arsize, r_awsize;
  logic [3:0]         r_arid;
  logic               r_arvalid, r_awvalid, r_rd_owner_d, r_wr_done;
  logic               w_pick_d, w_pick_i, w_raw_hit, w_wr_take, w_w_hs, w_wlast, w_r_beat;
  logic               w_unused;

  // The hazard compare only sees a write that was latched in an earlier cycle.
  assign w_raw_hit = (r_wr_state != W_IDLE) &&
                     (d_rd_addr[31:LINE_W] == r_awaddr[31:LINE_W]);
  assign w_wlast   = (r_beat_cnt == r_awlen);

  // Read arbitration and next-state.
  always_comb begin
    w_rd_next = r_rd_state;
    w_pick_d  = 1'b0;
    w_pick_i  = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        if (d_rd_req && !w_raw_hit) begin
          w_pick_d  = 1'b1;
          w_rd_next = R_AR;
        end else if (i_rd_req) begin
          w_pick_i  = 1'b1;
          w_rd_next = R_AR;
        end else begin
          w_rd_next = R_IDLE;
        end
      end
      R_AR:    w_rd_next = axi.arready ? R_DATA : R_AR;
      R_DATA:  w_rd_next = (axi.rvalid && axi.rlast) ? R_IDLE : R_DATA;
      default: w_rd_next = R_IDLE;
    endcase
  end

  // Read state and AR channel registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rd_state   <= R_IDLE;
      r_araddr     <= 32'd0;
      r_arlen      <= '0;
      r_arsize     <= 3'b000;
      r_arid       <= 4'd0;
      r_arvalid    <= 1'b0;
      r_rd_owner_d <= 1'b0;
    end else begin
      r_rd_state <= w_rd_next;
      r_arvalid  <= (w_rd_next == R_AR);
      if (w_pick_d) begin
        r_araddr     <= d_rd_addr;
        r_arlen      <= d_rd_len;
        r_arsize     <= d_rd_size;
        r_arid       <= 4'd1;
        r_rd_owner_d <= 1'b1;
      end else if (w_pick_i) begin
        r_araddr     <= i_rd_addr;
        r_arlen      <= i_rd_len;
        r_arsize     <= 3'b010;
        r_arid       <= 4'd0;
        r_rd_owner_d <= 1'b0;
      end
    end
  end

  // Write next-state; AW and W are strictly serialised.
  always_comb begin
    w_wr_next = r_wr_state;
    w_wr_take = 1'b0;
    w_w_hs    = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        if (d_wr_req) begin
          w_wr_take = 1'b1;
          w_wr_next = W_AW;
        end else begin
          w_wr_next = W_IDLE;
        end
      end
      W_AW: w_wr_next = axi.awready ? W_DATA : W_AW;
      W_DATA: begin
        w_w_hs    = d_wd_valid && axi.wready;
        w_wr_next = (w_w_hs && w_wlast) ? W_B : W_DATA;
      end
      W_B:     w_wr_next = axi.bvalid ? W_IDLE : W_B;
      default: w_wr_next = W_IDLE;
    endcase
  end

  // Write state, AW registers, beat counter and completion pulse.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr_state <= W_IDLE;
      r_awaddr   <= 32'd0;
      r_awlen    <= '0;
      r_awsize   <= 3'b000;
      r_awvalid  <= 1'b0;
      r_beat_cnt <= '0;
      r_wr_done  <= 1'b0;
    end else begin
      r_wr_state <= w_wr_next;
      r_awvalid  <= (w_wr_next == W_AW);
      r_wr_done  <= (r_wr_state == W_B) && axi.bvalid;
      if (w_wr_take) begin
        r_awaddr <= d_wr_addr;
        r_awlen  <= d_wr_len;
        r_awsize <= d_wr_size;
      end
      if (w_w_hs) begin
        r_beat_cnt <= w_wlast ? '0 : r_beat_cnt + MAX_LEN'(1);
      end
    end
  end

  assign w_r_beat    = (r_rd_state == R_DATA) && axi.rvalid;
  assign i_rd_gnt    = w_pick_i;
  assign d_rd_gnt    = w_pick_d;
  assign i_rd_valid  = w_r_beat && !r_rd_owner_d;
  assign d_rd_valid  = w_r_beat && r_rd_owner_d;
  assign rd_data     = axi.rdata;
  assign rd_last     = w_r_beat && axi.rlast;
  assign d_wr_gnt    = w_wr_take;
  assign d_wd_ready  = (r_wr_state == W_DATA) && axi.wready;
  assign d_wr_done   = r_wr_done;

  assign axi.arid    = r_arid;
  assign axi.araddr  = r_araddr;
  assign axi.arlen   = r_arlen;
  assign axi.arsize  = r_arsize;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = r_arvalid;
  assign axi.rready  = (r_rd_state == R_DATA);
  assign axi.awid    = 4'd1;
  assign axi.awaddr  = r_awaddr;
  assign axi.awlen   = r_awlen;
  assign axi.awsize  = r_awsize;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'b0000;
  assign axi.awprot  = 3'b000;
  assign axi.awvalid = r_awvalid;
  assign axi.wid     = 4'd1;
  assign axi.wdata   = d_wd_data;
  assign axi.wstrb   = d_wd_strb;
  assign axi.wlast   = (r_wr_state == W_DATA) && w_wlast;
  assign axi.wvalid  = (r_wr_state == W_DATA) && d_wd_valid;
  assign axi.bready  = (r_wr_state == W_B);

  // Response IDs and status codes carry nothing the core acts on.
  assign w_unused = ^{axi.rid, axi.rresp, axi.bid, axi.bresp};

endmodule

// File: tb/tb_axi_master_bridge.sv
// Bench for axi_master_bridge: table-driven read arbitration plus hand-written write,
// read-after-write hazard and mid-burst reset sequences, checked through beat scoreboards.
module tb_axi_master_bridge;
  logic        aclk = 1'b0;
  logic        areset;
  logic        i_rd_req, d_rd_req, d_wr_req, d_wd_valid;
  logic [31:0] i_rd_addr, d_rd_addr, d_wr_addr, d_wd_data;
  logic [7:0]  i_rd_len, d_rd_len, d_wr_len;
  logic [2:0]  d_rd_size, d_wr_size;
  logic [3:0]  d_wd_strb;
  logic        i_rd_gnt, d_rd_gnt, i_rd_valid, d_rd_valid, rd_last;
  logic        d_wr_gnt, d_wd_ready, d_wr_done;
  logic [31:0] rd_data;

  axi_master_bridge_if ax();

  axi_master_bridge dut (
    .aclk(aclk), .areset(areset),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_rd_len(i_rd_len), .i_rd_gnt(i_rd_gnt),
    .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_rd_len(d_rd_len), .d_rd_size(d_rd_size),
    .d_rd_gnt(d_rd_gnt), .i_rd_valid(i_rd_valid), .d_rd_valid(d_rd_valid),
    .rd_data(rd_data), .rd_last(rd_last),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_len(d_wr_len), .d_wr_size(d_wr_size),
    .d_wr_gnt(d_wr_gnt), .d_wd_valid(d_wd_valid), .d_wd_data(d_wd_data), .d_wd_strb(d_wd_strb),
    .d_wd_ready(d_wd_ready), .d_wr_done(d_wr_done),
    .axi(ax)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [31:0] data; logic own_d; logic last; } rbeat_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } wbeat_t;
  typedef struct {
    logic d_req; logic i_req; logic [31:0] d_addr; logic [7:0] d_len; logic [2:0] d_size;
    logic [31:0] i_addr; logic [7:0] i_len; int ar_wait;
    logic exp_d; logic [3:0] exp_arid; logic [31:0] exp_araddr; logic [7:0] exp_arlen;
    logic [2:0] exp_arsize;
  } rd_vec_t;

  rbeat_t  rq[$];
  wbeat_t  wq[$];
  rd_vec_t tbl[4];
  int      checks   = 0;
  int      failures = 0;
  logic    raw_same;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic raw_chk();
    if (raw_same) begin
      chk("raw_block_gnt", d_rd_gnt, 0);
      chk("raw_block_ar", ax.arvalid, 0);
    end
  endtask

  // Entered in R_AR; plays the slave side of AR and R with a gap every third cycle.
  task automatic serve_read(input int ar_wait, input logic [31:0] ea, input logic [7:0] el,
                            input logic [31:0] seed, input logic own_d);
    rbeat_t e;
    int sent;
    int guard;
    for (int k = 0; k < ar_wait; k++) begin
      ax.arready = 1'b0;
      settle();
      chk("ar_hold_valid", ax.arvalid, 1);
      chk("ar_hold_addr", ax.araddr, ea);
      chk("ar_hold_len", ax.arlen, el);
      chk("ar_no_regnt", {i_rd_gnt, d_rd_gnt}, 0);
      chk("ar_no_rready", ax.rready, 0);
      step();
    end
    ax.arready = 1'b1;
    settle();
    chk("ar_valid_hs", ax.arvalid, 1);
    chk("ar_addr_hs", ax.araddr, ea);
    step();
    ax.arready = 1'b0;
    settle();
    chk("ar_drop", ax.arvalid, 0);
    for (int b = 0; b <= int'(el); b++) rq.push_back('{seed + b, own_d, (b == int'(el))});
    sent  = 0;
    guard = 0;
    while (sent <= int'(el) && guard < 64) begin
      if ((guard % 3) == 1) begin
        ax.rvalid = 1'b0;
        settle();
        chk("r_gap_valid", {i_rd_valid, d_rd_valid}, 0);
      end else begin
        ax.rvalid = 1'b1;
        ax.rdata  = seed + sent;
        ax.rlast  = (sent == int'(el));
        ax.rid    = 4'hF;
        ax.rresp  = 2'b10;
        settle();
        chk("r_rready", ax.rready, 1);
        e = rq.pop_front();
        chk("r_data", rd_data, e.data);
        chk("r_owner", {d_rd_valid, i_rd_valid}, e.own_d ? 2'b10 : 2'b01);
        chk("r_last", rd_last, e.last);
        sent++;
      end
      step();
      guard++;
    end
    ax.rvalid = 1'b0;
    ax.rlast  = 1'b0;
    settle();
    chk("r_beat_count", sent, int'(el) + 1);
    chk("r_rready_idle", ax.rready, 0);
  endtask

  // Entered in W_AW; toggles wready during data, holds bvalid off for b_wait cycles.
  task automatic serve_write(input logic [31:0] ea, input logic [7:0] el, input logic [2:0] es,
                             input logic [3:0] strb, input int aw_wait, input int b_wait);
    wbeat_t e;
    int n;
    int guard;
    for (int b = 0; b <= int'(el); b++) wq.push_back('{32'hA500_0000 + b, strb, (b == int'(el))});
    d_wd_valid = 1'b1;
    d_wd_strb  = strb;
    d_wd_data  = 32'hA500_0000;
    for (int k = 0; k < aw_wait; k++) begin
      ax.awready = 1'b0;
      settle();
      chk("aw_hold_valid", ax.awvalid, 1);
      chk("aw_hold_addr", ax.awaddr, ea);
      chk("aw_w_serial", ax.wvalid, 0);
      raw_chk();
      step();
    end
    ax.awready = 1'b1;
    settle();
    chk("aw_valid", ax.awvalid, 1);
    chk("aw_addr", ax.awaddr, ea);
    chk("aw_len", ax.awlen, el);
    chk("aw_size", ax.awsize, es);
    chk("aw_id", ax.awid, 1);
    chk("aw_burst", ax.awburst, 1);
    chk("aw_w_serial", ax.wvalid, 0);
    raw_chk();
    step();
    ax.awready = 1'b0;
    n     = 0;
    guard = 0;
    while (n <= int'(el) && guard < 64) begin
      d_wd_data = 32'hA500_0000 + n;
      ax.wready = ((guard % 2) == 1);
      settle();
      chk("w_valid", ax.wvalid, 1);
      chk("w_ready_pass", d_wd_ready, ax.wready);
      chk("aw_drop", ax.awvalid, 0);
      chk("w_id", ax.wid, 1);
      raw_chk();
      if (ax.wready) begin
        e = wq.pop_front();
        chk("w_data", ax.wdata, e.data);
        chk("w_strb", ax.wstrb, e.strb);
        chk("w_last", ax.wlast, e.last);
        n++;
      end
      step();
      guard++;
    end
    chk("w_beat_count", n, int'(el) + 1);
    ax.wready = 1'b1;
    settle();
    chk("w_extra_ready", d_wd_ready, 0);
    chk("w_extra_valid", ax.wvalid, 0);
    chk("b_ready", ax.bready, 1);
    raw_chk();
    d_wd_valid = 1'b0;
    ax.wready  = 1'b0;
    step();
    for (int k = 0; k < b_wait; k++) begin
      settle();
      chk("b_wait_done", d_wr_done, 0);
      raw_chk();
      step();
    end
    ax.bvalid = 1'b1;
    ax.bresp  = 2'b11;
    settle();
    chk("b_hs_ready", ax.bready, 1);
    chk("b_hs_done", d_wr_done, 0);
    raw_chk();
    step();
    ax.bvalid = 1'b0;
    settle();
    chk("wr_done_pulse", d_wr_done, 1);
    chk("b_ready_idle", ax.bready, 0);
    if (raw_same) chk("raw_release", d_rd_gnt, 1);
    step();
    settle();
    chk("wr_done_clear", d_wr_done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1; raw_same = 1'b0;
    i_rd_req = 1'b0; i_rd_addr = 32'd0; i_rd_len = 8'd0;
    d_rd_req = 1'b0; d_rd_addr = 32'd0; d_rd_len = 8'd0; d_rd_size = 3'b000;
    d_wr_req = 1'b0; d_wr_addr = 32'd0; d_wr_len = 8'd0; d_wr_size = 3'b000;
    d_wd_valid = 1'b0; d_wd_data = 32'd0; d_wd_strb = 4'h0;
    ax.arready = 1'b0; ax.rid = 4'd0; ax.rdata = 32'd0; ax.rresp = 2'b00; ax.rlast = 1'b0;
    ax.rvalid = 1'b0; ax.awready = 1'b0; ax.wready = 1'b0; ax.bid = 4'd0; ax.bresp = 2'b00;
    ax.bvalid = 1'b0;

    tbl[0] = '{1'b1, 1'b1, 32'h1C00_0100, 8'd3, 3'b010, 32'h0040_0000, 8'd3, 0,
               1'b1, 4'd1, 32'h1C00_0100, 8'd3, 3'b010};
    tbl[1] = '{1'b0, 1'b1, 32'h0, 8'd0, 3'b000, 32'h0040_0000, 8'd3, 5,
               1'b0, 4'd0, 32'h0040_0000, 8'd3, 3'b010};
    tbl[2] = '{1'b1, 1'b0, 32'h1C00_0203, 8'd0, 3'b000, 32'h0, 8'd0, 1,
               1'b1, 4'd1, 32'h1C00_0203, 8'd0, 3'b000};
    tbl[3] = '{1'b0, 1'b1, 32'h0, 8'd0, 3'b000, 32'hBFC0_0000, 8'd7, 2,
               1'b0, 4'd0, 32'hBFC0_0000, 8'd7, 3'b010};

    step(); step();
    d_wd_valid = 1'b1;
    settle();
    chk("rst_arvalid", ax.arvalid, 0);
    chk("rst_rready", ax.rready, 0);
    chk("rst_awvalid", ax.awvalid, 0);
    chk("rst_wvalid", ax.wvalid, 0);
    chk("rst_bready", ax.bready, 0);
    chk("rst_araddr", ax.araddr, 0);
    chk("rst_awaddr", ax.awaddr, 0);
    chk("rst_lens", {ax.arlen, ax.awlen}, 0);
    chk("rst_pulses", {i_rd_gnt, d_rd_gnt, d_wr_gnt, d_wr_done, i_rd_valid, d_rd_valid}, 0);
    areset = 1'b0;
    d_wd_valid = 1'b0;
    step();

    // Read arbitration table
    for (int idx = 0; idx < 4; idx++) begin
      d_rd_req = tbl[idx].d_req; d_rd_addr = tbl[idx].d_addr;
      d_rd_len = tbl[idx].d_len; d_rd_size = tbl[idx].d_size;
      i_rd_req = tbl[idx].i_req; i_rd_addr = tbl[idx].i_addr; i_rd_len = tbl[idx].i_len;
      settle();
      chk("tbl_gnt_d", d_rd_gnt, tbl[idx].exp_d);
      chk("tbl_gnt_i", i_rd_gnt, !tbl[idx].exp_d);
      step();
      if (tbl[idx].exp_d) d_rd_req = 1'b0;
      else i_rd_req = 1'b0;
      settle();
      chk("tbl_arvalid", ax.arvalid, 1);
      chk("tbl_arid", ax.arid, tbl[idx].exp_arid);
      chk("tbl_araddr", ax.araddr, tbl[idx].exp_araddr);
      chk("tbl_arlen", ax.arlen, tbl[idx].exp_arlen);
      chk("tbl_arsize", ax.arsize, tbl[idx].exp_arsize);
      chk("tbl_arburst", ax.arburst, 1);
      serve_read(tbl[idx].ar_wait, tbl[idx].exp_araddr, tbl[idx].exp_arlen,
                 32'hC0DE_0000 + idx * 256, tbl[idx].exp_d);
    end
    i_rd_req = 1'b0;
    d_rd_req = 1'b0;
    step();

    // Four-beat write with toggling wready
    d_wr_req = 1'b1; d_wr_addr = 32'h0000_0200; d_wr_len = 8'd3; d_wr_size = 3'b010;
    settle();
    chk("wr_gnt", d_wr_gnt, 1);
    step();
    settle();
    chk("wr_gnt_once", d_wr_gnt, 0);
    d_wr_req = 1'b0;
    serve_write(32'h0000_0200, 8'd3, 3'b010, 4'hF, 2, 2);

    // Single-beat byte write with a same-line data read held off until completion
    d_wr_req = 1'b1; d_wr_addr = 32'h1C00_0100; d_wr_len = 8'd0; d_wr_size = 3'b000;
    settle();
    chk("raw_wr_gnt", d_wr_gnt, 1);
    step();
    d_wr_req = 1'b0;
    raw_same = 1'b1;
    d_rd_req = 1'b1; d_rd_addr = 32'h1C00_0108; d_rd_len = 8'd0; d_rd_size = 3'b010;
    serve_write(32'h1C00_0100, 8'd0, 3'b000, 4'b0100, 1, 3);
    raw_same = 1'b0;
    d_rd_req = 1'b0;
    settle();
    chk("raw_arid", ax.arid, 1);
    chk("raw_araddr", ax.araddr, 32'h1C00_0108);
    serve_read(0, 32'h1C00_0108, 8'd0, 32'h1111_0000, 1'b1);
    step();

    // Different-line read proceeds while a write is still in W_AW
    d_wr_req = 1'b1; d_wr_addr = 32'h1C00_0100; d_wr_len = 8'd1; d_wr_size = 3'b010;
    settle();
    chk("dl_wr_gnt", d_wr_gnt, 1);
    step();
    d_wr_req = 1'b0;
    d_rd_req = 1'b1; d_rd_addr = 32'h1C00_0200; d_rd_len = 8'd1; d_rd_size = 3'b010;
    settle();
    chk("dl_rd_gnt", d_rd_gnt, 1);
    chk("dl_awvalid", ax.awvalid, 1);
    step();
    d_rd_req = 1'b0;
    settle();
    chk("dl_arvalid", ax.arvalid, 1);
    serve_read(0, 32'h1C00_0200, 8'd1, 32'h2222_0000, 1'b1);
    serve_write(32'h1C00_0100, 8'd1, 3'b010, 4'hF, 0, 0);
    step();

    // Same-cycle data read and write to one line are both accepted
    d_wr_req = 1'b1; d_wr_addr = 32'h0000_3000; d_wr_len = 8'd0; d_wr_size = 3'b010;
    d_rd_req = 1'b1; d_rd_addr = 32'h0000_3004; d_rd_len = 8'd0; d_rd_size = 3'b010;
    settle();
    chk("sim_wr_gnt", d_wr_gnt, 1);
    chk("sim_rd_gnt", d_rd_gnt, 1);
    step();
    d_wr_req = 1'b0;
    d_rd_req = 1'b0;
    serve_read(1, 32'h0000_3004, 8'd0, 32'h3333_0000, 1'b1);
    serve_write(32'h0000_3000, 8'd0, 3'b010, 4'hF, 0, 1);
    step();

    // Reset in the middle of a read burst
    i_rd_req = 1'b1; i_rd_addr = 32'h0000_0100; i_rd_len = 8'd3;
    settle();
    chk("mr_gnt", i_rd_gnt, 1);
    step();
    i_rd_req = 1'b0;
    ax.arready = 1'b1;
    settle();
    step();
    ax.arready = 1'b0;
    ax.rvalid = 1'b1; ax.rdata = 32'h4444_0000; ax.rlast = 1'b0;
    settle();
    chk("mr_beat", i_rd_valid, 1);
    step();
    ax.rvalid = 1'b0;
    areset = 1'b1;
    step();
    areset = 1'b0;
    settle();
    chk("mr_arvalid", ax.arvalid, 0);
    chk("mr_rready", ax.rready, 0);
    chk("mr_araddr", ax.araddr, 0);
    d_rd_req = 1'b1; d_rd_addr = 32'h0000_0040; d_rd_len = 8'd1; d_rd_size = 3'b010;
    settle();
    chk("mr_new_gnt", d_rd_gnt, 1);
    step();
    d_rd_req = 1'b0;
    settle();
    chk("mr_new_arid", ax.arid, 1);
    serve_read(0, 32'h0000_0040, 8'd1, 32'h5555_0000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
